photon_plant_emulator: RTL and testbench

- Closed-loop optical bench emulator: the plant on the far side of photon_fsm.
- Consumes actuator commands A1..A6 and produces sensor flags S1..S6, closing the loop around the controller in simulation and on FPGA bring-up.
- Models one photon at a time: source fire, flight through a path/phase selector, detection on detector H or V, detector dead time, and shutter abort.
- Exposes its own 3-bit state and saturating per-detector photon counters.

---
 rtl/photon_plant_emulator.sv | 160 ++++++++++++++++
 tb/tb_photon_plant_emulator.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/photon_plant_emulator.sv
// Optical bench plant model: one photon at a time from source fire through flight,
// detection on H or V, detector dead time and shutter abort, with saturating counters.
module photon_plant_emulator #(
  parameter int unsigned FLIGHT_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 3,
  parameter int unsigned CW            = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          A1,
  input  logic          A2,
  input  logic          A3,
  input  logic          A4,
  input  logic          A5,
  input  logic          A6,
  output logic          S1,
  output logic          S2,
  output logic          S3,
  output logic          S4,
  output logic          S5,
  output logic          S6,
  output logic [2:0]    state,
  output logic [CW-1:0] count_h,
  output logic [CW-1:0] count_v
);

  localparam int unsigned TMax = (FLIGHT_CYCLES > HOLD_CYCLES) ? FLIGHT_CYCLES : HOLD_CYCLES;
  // Timer only ever holds values up to TMax - 1.
  localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;

  typedef enum logic [2:0] {
    StIdle    = 3'b000,
    StEmit    = 3'b001,
    StFlight  = 3'b010,
    StDetect  = 3'b011,
    StHold    = 3'b100,
    StBlocked = 3'b101
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            path_q, path_d;
  logic            phase_q, phase_d;
  logic            det_q, det_d;
  logic            a1_q;
  logic [CW-1:0]   count_h_q, count_h_d;
  logic [CW-1:0]   count_v_q, count_v_d;
  logic [5:0]      sens_q, sens_d;
  logic            fire;

  assign fire = A1 & ~a1_q;

  // Next-state logic for the photon lifecycle and the per-shot latches.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    path_d  = path_q;
    phase_d = phase_q;
    det_d   = det_q;
    case (state_q)
      StIdle: begin
        if (fire && A4) begin
          state_d = StEmit;
          path_d  = A2;
          phase_d = A3;
        end
      end
      StEmit: begin
        state_d = StFlight;
        timer_d = TW'(FLIGHT_CYCLES - 1);
      end
      StFlight: begin
        // Shutter wins over a same-edge timer expiry.
        if (A6) begin
          state_d = StBlocked;
        end else if (timer_q == '0) begin
          state_d = StDetect;
          det_d   = path_q ^ phase_q;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StDetect: begin
        state_d = StHold;
        timer_d = TW'(HOLD_CYCLES - 1);
      end
      StHold: begin
        if (timer_q == '0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StBlocked: begin
        if (!A6) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating detection counters; clear has priority over a same-edge increment.
  always_comb begin
    count_h_d = count_h_q;
    count_v_d = count_v_q;
    if (A5) begin
      count_h_d = '0;
      count_v_d = '0;
    end else if (state_q == StDetect) begin
      if (!det_q && (count_h_q != {CW{1'b1}})) count_h_d = count_h_q + CW'(1);
      if (det_q && (count_v_q != {CW{1'b1}})) count_v_d = count_v_q + CW'(1);
    end
  end

  // Sensor flags decoded from the next state so the registered copies track state exactly.
  always_comb begin
    sens_d    = '0;
    sens_d[0] = (state_d == StIdle);
    sens_d[1] = (state_d == StEmit);
    sens_d[2] = (state_d == StFlight);
    sens_d[3] = ((state_d == StDetect) || (state_d == StHold)) && !det_d;
    sens_d[4] = ((state_d == StDetect) || (state_d == StHold)) && det_d;
    sens_d[5] = (state_d == StBlocked);
  end

  // All state, counters and registered sensor outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      path_q    <= 1'b0;
      phase_q   <= 1'b0;
      det_q     <= 1'b0;
      a1_q      <= 1'b0;
      count_h_q <= '0;
      count_v_q <= '0;
      sens_q    <= 6'b000001;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      path_q    <= path_d;
      phase_q   <= phase_d;
      det_q     <= det_d;
      a1_q      <= A1;
      count_h_q <= count_h_d;
      count_v_q <= count_v_d;
      sens_q    <= sens_d;
    end
  end

  assign state   = state_q;
  assign count_h = count_h_q;
  assign count_v = count_v_q;
  assign S1      = sens_q[0];
  assign S2      = sens_q[1];
  assign S3      = sens_q[2];
  assign S4      = sens_q[3];
  assign S5      = sens_q[4];
  assign S6      = sens_q[5];

endmodule

// File: tb/tb_photon_plant_emulator.sv
// Bench for photon_plant_emulator: directed scenarios plus random traffic, each cycle
// compared against a shot-schedule reference model.
module tb_photon_plant_emulator;

  localparam int unsigned F  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned CW = 8;

  localparam int IDLE = 0, EMIT = 1, FLIGHT = 2, DETECT = 3, HOLD = 4, BLOCKED = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic A1 = 1'b0, A2 = 1'b0, A3 = 1'b0, A4 = 1'b0, A5 = 1'b0, A6 = 1'b0;
  logic S1, S2, S3, S4, S5, S6;
  logic [2:0] state;
  logic [CW-1:0] count_h, count_v;
  logic [24:0] obs;

  always #5 clk = ~clk;

  photon_plant_emulator #(
    .FLIGHT_CYCLES(F),
    .HOLD_CYCLES  (H),
    .CW           (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .A1     (A1),
    .A2     (A2),
    .A3     (A3),
    .A4     (A4),
    .A5     (A5),
    .A6     (A6),
    .S1     (S1),
    .S2     (S2),
    .S3     (S3),
    .S4     (S4),
    .S5     (S5),
    .S6     (S6),
    .state  (state),
    .count_h(count_h),
    .count_v(count_v)
  );

  assign obs = {state, S1, S2, S3, S4, S5, S6, count_h, count_v};

  int vectors = 0;
  int miscompares = 0;

  // Reference model: an accepted shot is a precomputed schedule of phases; abort drops it.
  int cur = IDLE;
  int sched[$];
  bit m_det = 1'b0;
  int mch = 0, mcv = 0;
  bit a1_prev = 1'b0;

  function automatic int pop_or_idle();
    if (sched.size() != 0) return sched.pop_front();
    return IDLE;
  endfunction

  task automatic model_edge();
    bit fire;
    if (rst) begin
      cur = IDLE; sched.delete(); mch = 0; mcv = 0; a1_prev = 1'b0; m_det = 1'b0;
      return;
    end
    fire = A1 && !a1_prev;
    a1_prev = A1;
    case (cur)
      IDLE: begin
        if (fire && A4) begin
          m_det = A2 ^ A3;
          sched.delete();
          sched.push_back(EMIT);
          repeat (F) sched.push_back(FLIGHT);
          sched.push_back(DETECT);
          repeat (H) sched.push_back(HOLD);
          cur = pop_or_idle();
        end
      end
      FLIGHT: begin
        if (A6) begin cur = BLOCKED; sched.delete(); end
        else cur = pop_or_idle();
      end
      DETECT: begin
        if (m_det) mcv = (mcv < 255) ? mcv + 1 : 255;
        else       mch = (mch < 255) ? mch + 1 : 255;
        cur = pop_or_idle();
      end
      BLOCKED: if (!A6) cur = IDLE;
      default: cur = pop_or_idle();
    endcase
    if (A5) begin mch = 0; mcv = 0; end
  endtask

  function automatic logic [24:0] exp_obs();
    logic click;
    click = (cur == DETECT) || (cur == HOLD);
    return {3'(cur), cur == IDLE, cur == EMIT, cur == FLIGHT, click && !m_det,
            click && m_det, cur == BLOCKED, 8'(mch), 8'(mcv)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      tick();
      vectors++;
      if (obs !== exp_obs()) begin
        miscompares++; $display("FAIL reset_model: got %h want %h", obs, exp_obs());
      end
    end
    vectors++;
    if (obs !== {3'b000, 6'b100000, 16'h0000}) begin
      miscompares++; $display("FAIL reset_const: got %h want %h", obs, {3'b000, 6'b100000, 16'h0});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_h();
    int s4n = 0, s5n = 0;
    A4 = 1'b1; A2 = 1'b0; A3 = 1'b0; A1 = 1'b1;
    tick();
    A1 = 1'b0;
    vectors++;
    if (obs !== exp_obs()) begin
      miscompares++; $display("FAIL basic_emit: got %h want %h", obs, exp_obs());
    end
    repeat (12) begin
      tick();
      s4n += int'(S4); s5n += int'(S5);
      vectors++;
      if (obs !== exp_obs()) begin
        miscompares++; $display("FAIL basic_trace: got %h want %h", obs, exp_obs());
      end
    end
    vectors++;
    if (s4n != 4 || s5n != 0 || count_h !== 8'd1 || count_v !== 8'd0) begin
      miscompares++;
      $display("FAIL basic_summary: got s4=%0d s5=%0d h=%0d v=%0d want s4=4 s5=0 h=1 v=0",
               s4n, s5n, count_h, count_v);
    end
  endtask

  task automatic test_phase_flip();
    for (int shot = 0; shot < 2; shot++) begin
      A2 = (shot == 1); A3 = 1'b1; A1 = 1'b1;
      tick();
      A1 = 1'b0;
      repeat (12) begin
        if (state == 3'b010) A2 = ~A2;
        tick();
        vectors++;
        if (obs !== exp_obs()) begin
          miscompares++; $display("FAIL phase_trace%0d: got %h want %h", shot, obs, exp_obs());
        end
      end
    end
    vectors++;
    if (count_h !== 8'd2 || count_v !== 8'd1) begin
      miscompares++;
      $display("FAIL phase_counts: got h=%0d v=%0d want h=2 v=1", count_h, count_v);
    end
  endtask

  task automatic test_abort();
    A2 = 1'b0; A3 = 1'b0; A1 = 1'b1;
    tick();
    A1 = 1'b0;
    repeat (2) tick();  // EMIT -> first, second FLIGHT cycle
    A6 = 1'b1;
    repeat (5) begin
      tick();
      vectors++;
      if (obs !== exp_obs() || state !== 3'b101 || S6 !== 1'b1) begin
        miscompares++; $display("FAIL abort_blocked: got %h want %h", obs, exp_obs());
      end
    end
    A6 = 1'b0;
    tick();
    vectors++;
    if (obs !== exp_obs() || state !== 3'b000 || S1 !== 1'b1) begin
      miscompares++; $display("FAIL abort_release: got %h want %h", obs, exp_obs());
    end
    // Shutter on the exact edge the flight timer expires.
    A1 = 1'b1;
    tick();
    A1 = 1'b0;
    repeat (F) begin
      tick();
      vectors++;
      if (obs !== exp_obs()) begin
        miscompares++; $display("FAIL abort_flight: got %h want %h", obs, exp_obs());
      end
    end
    A6 = 1'b1;
    tick();
    vectors++;
    if (obs !== exp_obs() || state !== 3'b101 || count_h !== 8'd2) begin
      miscompares++; $display("FAIL abort_expiry: got %h want %h", obs, exp_obs());
    end
    A6 = 1'b0;
    tick();
  endtask

  task automatic test_dropped();
    int emits = 0;
    bit seen_hold = 1'b0;
    A4 = 1'b0; A1 = 1'b1;
    repeat (3) begin
      tick(); emits += int'(S2);
    end
    A4 = 1'b1;
    repeat (20) begin
      tick(); emits += int'(S2);
      vectors++;
      if (obs !== exp_obs()) begin
        miscompares++; $display("FAIL dropped_held: got %h want %h", obs, exp_obs());
      end
    end
    A1 = 1'b0; tick();
    A1 = 1'b1; tick(); emits += int'(S2);
    A1 = 1'b0;
    for (int i = 0; i < 20 && !seen_hold; i++) begin
      tick(); emits += int'(S2);
      seen_hold = (state == 3'b100);
    end
    vectors++;
    if (!seen_hold) begin
      miscompares++; $display("FAIL dropped_wait_hold: got state %0d want 4", state);
    end
    A1 = 1'b1;
    tick(); emits += int'(S2);
    A1 = 1'b0;
    repeat (10) begin
      tick(); emits += int'(S2);
      vectors++;
      if (obs !== exp_obs()) begin
        miscompares++; $display("FAIL dropped_hold: got %h want %h", obs, exp_obs());
      end
    end
    vectors++;
    if (emits != 1 || state !== 3'b000) begin
      miscompares++; $display("FAIL dropped_emits: got %0d st=%0d want 1 st=0", emits, state);
    end
  endtask

  task automatic test_counters();
    bit seen_det = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    A2 = 1'b0; A3 = 1'b0; A4 = 1'b1;
    repeat (256) begin
      A1 = 1'b1; tick(); A1 = 1'b0;
      repeat (1 + F + 1 + H) begin
        tick();
        vectors++;
        if (obs !== exp_obs()) begin
          miscompares++; $display("FAIL count_trace: got %h want %h", obs, exp_obs());
        end
      end
    end
    vectors++;
    if (count_h !== 8'd255 || count_v !== 8'd0) begin
      miscompares++; $display("FAIL count_sat: got h=%0d v=%0d want h=255 v=0", count_h, count_v);
    end
    A1 = 1'b1; tick(); A1 = 1'b0;
    for (int i = 0; i < 10 && !seen_det; i++) begin
      tick();
      seen_det = (state == 3'b011);
    end
    A5 = 1'b1;
    tick();
    A5 = 1'b0;
    vectors++;
    if (!seen_det || obs !== exp_obs() || count_h !== 8'd0 || count_v !== 8'd0) begin
      miscompares++;
      $display("FAIL count_clear: got %h h=%0d v=%0d want %h h=0 v=0", obs, count_h, count_v,
               exp_obs());
    end
    repeat (H + 2) tick();
  endtask

  task automatic test_mid_reset();
    for (int which = 0; which < 2; which++) begin
      bit hit = 1'b0;
      A2 = 1'b1; A3 = 1'b0; A1 = 1'b1; tick(); A1 = 1'b0;
      for (int i = 0; i < 12 && !hit; i++) begin
        tick();
        hit = (which == 0) ? (state == 3'b010) : (state == 3'b100);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (!hit || obs !== exp_obs() || obs !== {3'b000, 6'b100000, 16'h0}) begin
        miscompares++; $display("FAIL midreset%0d: got %h want %h", which, obs, exp_obs());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) A1 = ~A1;
      A2 = 1'($urandom_range(0, 1));
      A3 = 1'($urandom_range(0, 1));
      A4 = ($urandom_range(0, 7) != 0);
      A5 = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 11) == 0) A6 = ~A6;
      rst = ($urandom_range(0, 299) == 0);
      tick();
      vectors++;
      if (obs !== exp_obs()) begin
        miscompares++; $display("FAIL random%0d: got %h want %h", i, obs, exp_obs());
      end
    end
    rst = 1'b0; A1 = 1'b0; A5 = 1'b0; A6 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_h();
    test_phase_flip();
    test_abort();
    test_dropped();
    test_counters();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
